// File: rtl/axil_master_bridge.sv
// axil_master_bridge: single-outstanding AXI4-Lite initiator fed by a valid/ready request port.
module axil_master_bridge #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH/8,
  parameter logic [2:0] PROT = 3'b000,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [STRB_WIDTH-1:0] req_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);
  typedef enum logic [2:0] {IDLE, WR, WR_B, RD_A, RD_D, RESP} state_t;
  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic aw_done, w_done, accept, aw_hs, w_hs, b_done, r_done, busy, timeout;
  logic unused_resp;
  assign unused_resp = ^{m_axil_bresp[0], m_axil_rresp[0]};
  assign accept = req_valid && req_ready;
  assign aw_hs = m_axil_awvalid && m_axil_awready;
  assign w_hs = m_axil_wvalid && m_axil_wready;
  assign b_done = (state == WR_B) && m_axil_bvalid;
  assign r_done = (state == RD_D) && m_axil_rvalid;
  assign busy = state inside {WR, WR_B, RD_A, RD_D};
`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] cnt;
  assign timeout = busy && (cnt == CW'(TIMEOUT_CYCLES-2)) && !b_done && !r_done;
  always_ff @(posedge clk) begin
    if (rst || accept)
      cnt <= '0;
    else if (busy)
      cnt <= cnt + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif
  assign req_ready = (state == IDLE) && !rst;
  assign m_axil_awvalid = (state == WR) && !aw_done;
  assign m_axil_wvalid = (state == WR) && !w_done;
  assign m_axil_arvalid = (state == RD_A);
  assign m_axil_bready = (state == WR_B);
  assign m_axil_rready = (state == RD_D);
  assign rsp_valid = (state == RESP);
  assign m_axil_awaddr = addr;
  assign m_axil_araddr = addr;
  assign m_axil_wdata = wdata;
  assign m_axil_wstrb = wstrb;
  assign m_axil_awprot = PROT;
  assign m_axil_arprot = PROT;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = accept ? (req_we ? WR : RD_A) : IDLE;
      WR:   state_n = ((aw_done || aw_hs) && (w_done || w_hs)) ? WR_B : WR;
      WR_B: state_n = m_axil_bvalid ? RESP : WR_B;
      RD_A: state_n = m_axil_arready ? RD_D : RD_A;
      RD_D: state_n = m_axil_rvalid ? RESP : RD_D;
      RESP: state_n = rsp_ready ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
    if (timeout)
      state_n = RESP;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      aw_done <= 1'b0;
      w_done <= 1'b0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
    end else begin
      state <= state_n;
      aw_done <= accept ? 1'b0 : (aw_done || aw_hs);
      w_done <= accept ? 1'b0 : (w_done || w_hs);
      if (timeout) begin
        rsp_err <= 1'b1;
        rsp_rdata <= '0;
      end else if (b_done) begin
        rsp_err <= m_axil_bresp[1];
        rsp_rdata <= '0;
      end else if (r_done) begin
        rsp_err <= m_axil_rresp[1];
        rsp_rdata <= m_axil_rdata;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (accept) begin
      addr <= req_addr;
      wdata <= req_wdata;
      wstrb <= req_wstrb;
    end
  end
endmodule
